// File: rtl/csa10_accum.sv
// csa10_accum: frame accumulator sitting behind a 10-bit carry-select adder.
// Sums 1..(2^LEN_W-1) unsigned operands from a valid/ready stream and returns
// the wrapped 10-bit total with a sticky carry-out flag. A zero-length frame
// reports an empty result (sum 0, no overflow).

// 10-bit carry-select adder: the low 5 bits ripple, and the high 5 bits are
// precomputed for both carry values and then selected by the low carry.
module csa10 (
    input  logic [9:0] a10,
    input  logic [9:0] b10,
    input  logic       in10,
    output logic [9:0] sum10,
    output logic       co10
);
    logic [5:0] lo_s;
    logic [5:0] hi0_s;
    logic [5:0] hi1_s;

    // Low half ripple sum plus both candidate high halves, then select.
    always_comb begin
        lo_s  = {1'b0, a10[4:0]} + {1'b0, b10[4:0]} + {5'd0, in10};
        hi0_s = {1'b0, a10[9:5]} + {1'b0, b10[9:5]};
        hi1_s = hi0_s + 6'd1;
        if (lo_s[5]) begin
            sum10 = {hi1_s[4:0], lo_s[4:0]};
            co10  = hi1_s[5];
        end else begin
            sum10 = {hi0_s[4:0], lo_s[4:0]};
            co10  = hi0_s[5];
        end
    end
endmodule

module csa10_accum #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [9:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_sum,
    output logic             out_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [9:0]       acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [9:0]       add_sum_s;
    logic             add_co_s;

    // The only datapath adder: accumulator plus incoming operand, no carry-in.
    csa10 u_csa10 (
        .a10   (acc_q),
        .b10   (in_data),
        .in10  (1'b0),
        .sum10 (add_sum_s),
        .co10  (add_co_s)
    );

    // Handshake flags come from the state register alone; the result is the
    // accumulator/overflow flops themselves, so they only change on an edge.
    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // Next-state and datapath update for the three-phase frame sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = 10'd0;
                    ovf_d = 1'b0;
                    if (len != LEN_ZERO) begin
                        rem_d   = len;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = add_sum_s;
                    ovf_d = ovf_q | add_co_s;
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 10'd0;
            ovf_q   <= 1'b0;
            rem_q   <= LEN_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end
endmodule
